// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with byte-lane write enables, selectable
// read-during-write behaviour, optional output register and post-reset clear sweep.
module dual_port_ram_be #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             en1,
  input  logic                             we1,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  input  logic [DATA_WIDTH-1:0]            data1,
  input  logic                             en2,
  input  logic                             we2,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be2,
  input  logic [ADDR_WIDTH-1:0]            addr2,
  input  logic [DATA_WIDTH-1:0]            data2,
  output logic [DATA_WIDTH-1:0]            out1,
  output logic [DATA_WIDTH-1:0]            out2,
  output logic                             valid1,
  output logic                             valid2,
  output logic                             busy,
  output logic                             collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    clr_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc1, acc2;
  logic                    same_addr;
  logic [NB-1:0]           wl1, wl2;
  logic [DATA_WIDTH-1:0]   rd1, rd2;

  logic [DATA_WIDTH-1:0]   out1_s1_q, out1_s1_d;
  logic [DATA_WIDTH-1:0]   out2_s1_q, out2_s1_d;
  logic                    vld1_s1_q, vld1_s1_d;
  logic                    vld2_s1_q, vld2_s1_d;
  logic                    coll_s1_q, coll_s1_d;

  // Clear-sweep controller
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we     = resetn;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  // Request qualification
  always_comb begin
    acc1      = resetn & en1 & ~busy;
    acc2      = resetn & en2 & ~busy;
    same_addr = (addr1 == addr2);
    wl1       = '0;
    wl2       = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      wl1[k] = acc1 & we1 & be1[k];
      wl2[k] = acc2 & we2 & be2[k];
    end
  end

  // Read data: partner-only lanes always show old contents; own-write lanes
  // show the stored result in new-data mode, where port 1 wins overlapping lanes.
  always_comb begin
    rd1 = mem[addr1];
    rd2 = mem[addr2];
    if (RDW_MODE == 1) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wl1[k]) begin
          rd1[k*BYTE_WIDTH +: BYTE_WIDTH] = data1[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wl2[k]) begin
          if (same_addr && wl1[k]) begin
            rd2[k*BYTE_WIDTH +: BYTE_WIDTH] = data1[k*BYTE_WIDTH +: BYTE_WIDTH];
          end else begin
            rd2[k*BYTE_WIDTH +: BYTE_WIDTH] = data2[k*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Port 1 is applied after port 2 so it owns overlapping lanes on a shared address.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr_q] <= '0;
    end else begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wl2[k]) begin
          mem[addr2][k*BYTE_WIDTH +: BYTE_WIDTH] <= data2[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wl1[k]) begin
          mem[addr1][k*BYTE_WIDTH +: BYTE_WIDTH] <= data1[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // First output stage
  always_comb begin
    out1_s1_d = acc1 ? rd1 : out1_s1_q;
    out2_s1_d = acc2 ? rd2 : out2_s1_q;
    vld1_s1_d = acc1;
    vld2_s1_d = acc2;
    coll_s1_d = acc1 & acc2 & same_addr & (we1 | we2);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out1_s1_q <= '0;
      out2_s1_q <= '0;
      vld1_s1_q <= 1'b0;
      vld2_s1_q <= 1'b0;
      coll_s1_q <= 1'b0;
    end else begin
      out1_s1_q <= out1_s1_d;
      out2_s1_q <= out2_s1_d;
      vld1_s1_q <= vld1_s1_d;
      vld2_s1_q <= vld2_s1_d;
      coll_s1_q <= coll_s1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] out1_s2_q, out1_s2_d;
      logic [DATA_WIDTH-1:0] out2_s2_q, out2_s2_d;
      logic                  vld1_s2_q, vld1_s2_d;
      logic                  vld2_s2_q, vld2_s2_d;
      logic                  coll_s2_q, coll_s2_d;

      always_comb begin
        out1_s2_d = vld1_s1_q ? out1_s1_q : out1_s2_q;
        out2_s2_d = vld2_s1_q ? out2_s1_q : out2_s2_q;
        vld1_s2_d = vld1_s1_q;
        vld2_s2_d = vld2_s1_q;
        coll_s2_d = coll_s1_q;
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          out1_s2_q <= '0;
          out2_s2_q <= '0;
          vld1_s2_q <= 1'b0;
          vld2_s2_q <= 1'b0;
          coll_s2_q <= 1'b0;
        end else begin
          out1_s2_q <= out1_s2_d;
          out2_s2_q <= out2_s2_d;
          vld1_s2_q <= vld1_s2_d;
          vld2_s2_q <= vld2_s2_d;
          coll_s2_q <= coll_s2_d;
        end
      end

      assign out1      = out1_s2_q;
      assign out2      = out2_s2_q;
      assign valid1    = vld1_s2_q;
      assign valid2    = vld2_s2_q;
      assign collision = coll_s2_q;
    end else begin : g_noreg
      assign out1      = out1_s1_q;
      assign out2      = out2_s1_q;
      assign valid1    = vld1_s1_q;
      assign valid2    = vld2_s1_q;
      assign collision = coll_s1_q;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: three RAM variants (old-data, new-data, output-registered) share one stimulus.
module tb_dual_port_ram_be;

  logic        clk;
  logic        resetn;
  logic        e1, w1, e2, w2;
  logic [3:0]  b1, b2, a1, a2;
  logic [31:0] d1, d2;

  logic [31:0] a_out1, a_out2, b_out1, b_out2, c_out1, c_out2;
  logic        a_v1, a_v2, a_busy, a_coll;
  logic        b_v1, b_v2, b_busy, b_coll;
  logic        c_v1, c_v2, c_busy, c_coll;

  int total = 0;
  int bad   = 0;
  int cnt;
  int noisy;

  dual_port_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                     .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)) u_a (
    .clk(clk), .resetn(resetn),
    .en1(e1), .we1(w1), .be1(b1), .addr1(a1), .data1(d1),
    .en2(e2), .we2(w2), .be2(b2), .addr2(a2), .data2(d2),
    .out1(a_out1), .out2(a_out2), .valid1(a_v1), .valid2(a_v2),
    .busy(a_busy), .collision(a_coll));

  dual_port_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                     .RDW_MODE(1), .OUT_REG(0), .INIT_CLEAR(1)) u_b (
    .clk(clk), .resetn(resetn),
    .en1(e1), .we1(w1), .be1(b1), .addr1(a1), .data1(d1),
    .en2(e2), .we2(w2), .be2(b2), .addr2(a2), .data2(d2),
    .out1(b_out1), .out2(b_out2), .valid1(b_v1), .valid2(b_v2),
    .busy(b_busy), .collision(b_coll));

  dual_port_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                     .RDW_MODE(0), .OUT_REG(1), .INIT_CLEAR(1)) u_c (
    .clk(clk), .resetn(resetn),
    .en1(e1), .we1(w1), .be1(b1), .addr1(a1), .data1(d1),
    .en2(e2), .we2(w2), .be2(b2), .addr2(a2), .data2(d2),
    .out1(c_out1), .out2(c_out2), .valid1(c_v1), .valid2(c_v2),
    .busy(c_busy), .collision(c_coll));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ie1, input logic iw1, input logic [3:0] ib1,
                     input logic [3:0] ia1, input logic [31:0] id1,
                     input logic ie2, input logic iw2, input logic [3:0] ib2,
                     input logic [3:0] ia2, input logic [31:0] id2);
    e1 = ie1; w1 = iw1; b1 = ib1; a1 = ia1; d1 = id1;
    e2 = ie2; w2 = iw2; b2 = ib2; a2 = ia2; d2 = id2;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Counts cycles with busy high from the current negedge; outputs must stay quiet.
  task automatic sweep(output int n, output int q);
    n = 0;
    q = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_busy !== 1'b1) break;
      n++;
      if (a_out1 !== 32'h0 || a_v1 !== 1'b0 || a_v2 !== 1'b0 || a_coll !== 1'b0 ||
          c_v1 !== 1'b0 || c_coll !== 1'b0) q++;
      @(negedge clk);
    end
  endtask

  initial begin
    resetn = 1'b0;
    e1 = 0; w1 = 0; b1 = 0; a1 = 0; d1 = 0;
    e2 = 0; w2 = 0; b2 = 0; a2 = 0; d2 = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_out1", a_out1, 32'h0);
    chk("rst_valid1", {31'h0, a_v1}, 32'h0);
    chk("rst_coll", {31'h0, a_coll}, 32'h0);
    chk("rst_busy", {31'h0, a_busy}, 32'h1);
    chk("rst_c_out1", c_out1, 32'h0);

    resetn = 1'b1;
    sweep(cnt, noisy);
    chk("busy_len", cnt, 32'd16);
    chk("busy_quiet", noisy, 32'd0);

    // All words zero after the sweep
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0);
      chk("clr_rd1", a_out1, 32'h0);
      chk("clr_v1", {31'h0, a_v1}, 32'h1);
      chk("clr_rd2", a_out2, 32'h0);
    end

    // Byte lanes
    cyc(1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    cyc(1'b1, 1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    chk("lane_rdw_old", a_out1, 32'hAABBCCDD);
    chk("lane_rdw_new", b_out1, 32'hAA22CC44);
    cyc(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    chk("lane_read", a_out1, 32'hAA22CC44);

    // Same-port read-during-write
    cyc(1'b1, 1'b1, 4'hF, 4'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    chk("rdw0_out1", a_out1, 32'h0);
    chk("rdw1_out1", b_out1, 32'hFFFFFFFF);
    chk("rdw_v1", {31'h0, a_v1}, 32'h1);
    idle();
    chk("hold_out1", b_out1, 32'hFFFFFFFF);
    chk("hold_v1", {31'h0, b_v1}, 32'h0);

    // Cross-port write/write
    cyc(1'b1, 1'b1, 4'h3, 4'd7, 32'h11111111, 1'b1, 1'b1, 4'h6, 4'd7, 32'h22222222);
    chk("ww_coll", {31'h0, a_coll}, 32'h1);
    chk("ww_old1", a_out1, 32'h0);
    chk("ww_new1", b_out1, 32'h00001111);
    chk("ww_new2", b_out2, 32'h00221100);
    idle();
    chk("ww_coll_end", {31'h0, a_coll}, 32'h0);
    chk("ww_coll_reg", {31'h0, c_coll}, 32'h1);
    cyc(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    chk("rr_out1", a_out1, 32'h00221111);
    chk("rr_out2", a_out2, 32'h00221111);
    chk("rr_coll", {31'h0, a_coll}, 32'h0);

    // Output-register latency
    cyc(1'b1, 1'b1, 4'hF, 4'd2, 32'h5A5A5A5A, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    idle();
    cyc(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    chk("oreg_early_v", {31'h0, c_v1}, 32'h0);
    chk("oreg_early_d", c_out1, 32'h0);
    idle();
    chk("oreg_out1", c_out1, 32'h5A5A5A5A);
    chk("oreg_v1", {31'h0, c_v1}, 32'h1);
    chk("noreg_hold", a_out1, 32'h5A5A5A5A);
    idle();
    chk("oreg_hold", c_out1, 32'h5A5A5A5A);
    chk("oreg_v1_low", {31'h0, c_v1}, 32'h0);

    // Reset in the middle of a sweep
    resetn = 1'b0;
    idle();
    resetn = 1'b1;
    repeat (8) idle();
    chk("mid_busy", {31'h0, a_busy}, 32'h1);
    resetn = 1'b0;
    idle();
    resetn = 1'b1;
    e1 = 1'b1; w1 = 1'b1; b1 = 4'hF; a1 = 4'd0; d1 = 32'hFFFFFFFF;
    sweep(cnt, noisy);
    e1 = 1'b0; w1 = 1'b0; b1 = 4'h0;
    chk("restart_len", cnt, 32'd16);
    chk("restart_quiet", noisy, 32'd0);
    cyc(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 4'h0, 4'd15, 32'h0);
    chk("busy_wr_drop", a_out1, 32'h0);
    chk("last_word_clr", a_out2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
